// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the single-port 256x16 data memory between the SPU
// (port 0) and the host/loader (port 1).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   mX_req/we/addr/w_data/lock    per-port request (X = 0 SPU, 1 host)
//   mX_gnt                        beat accepted this cycle (combinational)
//   mX_r_valid/r_data             read return, exactly one cycle after the read beat
//   mem_rd/wr/addr/w_data         memory command, muxed from the granted port
//   mem_r_data                    memory read data, valid one cycle after mem_rd
//
// A port may hold ownership across beats with mX_lock. Ownership is cut
// after MAX_LOCK beats if the other port is waiting, and that port then
// wins the next arbitration.
//
// Build option: define DM_ARB_RR_EN for round-robin arbitration in IDLE;
// otherwise port 0 always wins ties.
module dm_port_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_w_data,
  input  logic              m0_lock,
  output logic              m0_gnt,
  output logic              m0_r_valid,
  output logic [DATA_W-1:0] m0_r_data,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_w_data,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_r_valid,
  output logic [DATA_W-1:0] m1_r_data,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_w_data,
  input  logic [DATA_W-1:0] mem_r_data
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);

  state_t     state;
  logic [7:0] lock_cnt;
  logic       starve;       // a port was cut off and must win next IDLE grant
  logic       starve_port;  // which port that is
  logic       rd_tag0, rd_tag1;
  logic       pref;         // port preferred in IDLE arbitration
  logic       g0, g1;
  logic       sat;

  assign sat = (lock_cnt == MAX_CNT);

`ifdef DM_ARB_RR_EN
  logic rr_ptr;
  assign pref = starve ? starve_port : rr_ptr;
`else
  assign pref = starve ? starve_port : 1'b0;
`endif

  // Grant: combinational from request and state, forced low in reset.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (!pref) begin
            if (m0_req)      g0 = 1'b1;
            else if (m1_req) g1 = 1'b1;
          end else begin
            if (m1_req)      g1 = 1'b1;
            else if (m0_req) g0 = 1'b1;
          end
        end
        // Owner is granted unless it has used up its lock budget and the
        // other port is waiting; that cycle nobody is granted.
        OWN0:    g0 = m0_req & ~(sat & m1_req);
        OWN1:    g1 = m1_req & ~(sat & m0_req);
        default: ;
      endcase
    end
  end

  assign m0_gnt     = g0;
  assign m1_gnt     = g1;
  assign mem_rd     = (g0 & ~m0_we) | (g1 & ~m1_we);
  assign mem_wr     = (g0 & m0_we)  | (g1 & m1_we);
  assign mem_addr   = g0 ? m0_addr   : (g1 ? m1_addr   : '0);
  assign mem_w_data = g0 ? m0_w_data : (g1 ? m1_w_data : '0);

  assign m0_r_valid = rd_tag0 & ~rst;
  assign m1_r_valid = rd_tag1 & ~rst;
  assign m0_r_data  = m0_r_valid ? mem_r_data : '0;
  assign m1_r_data  = m1_r_valid ? mem_r_data : '0;

  // Per-cycle view of the current owner's and the other port's inputs.
  logic own_req, own_lock, oth_req, own_id;
  assign own_id   = (state == OWN1);
  assign own_req  = own_id ? m1_req  : m0_req;
  assign own_lock = own_id ? m1_lock : m0_lock;
  assign oth_req  = own_id ? m0_req  : m1_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lock_cnt    <= '0;
      starve      <= 1'b0;
      starve_port <= 1'b0;
      rd_tag0     <= 1'b0;
      rd_tag1     <= 1'b0;
`ifdef DM_ARB_RR_EN
      rr_ptr      <= 1'b0;
`endif
    end else begin
      rd_tag0 <= g0 & ~m0_we;
      rd_tag1 <= g1 & ~m1_we;
      case (state)
        IDLE: begin
          if (g0 | g1) begin
            if (starve && (g1 == starve_port)) starve <= 1'b0;
`ifdef DM_ARB_RR_EN
            rr_ptr <= ~g1;
`endif
            if (g1 ? m1_lock : m0_lock) begin
              state    <= g1 ? OWN1 : OWN0;
              lock_cnt <= 8'd1;
            end
          end
        end
        OWN0, OWN1: begin
          if (sat && oth_req) begin
            state       <= IDLE;
            lock_cnt    <= '0;
            starve      <= 1'b1;
            starve_port <= ~own_id;
          end else if (!own_req || !own_lock) begin
            state    <= IDLE;
            lock_cnt <= '0;
          end else if (!sat) begin
            lock_cnt <= lock_cnt + 8'd1;
          end
        end
        default: begin
          state    <= IDLE;
          lock_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter. Two instances: u_dut (MAX_LOCK=8) for
// the general tests, u_dut3 (MAX_LOCK=3) for the starvation-limit test.
// Read returns of u_dut are checked against a scoreboard queue filled when
// each read beat is driven.
module tb_dm_port_arbiter;

`ifdef DM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 0, m0_we = 0, m0_lock = 0;
  logic [7:0]  m0_addr = 0;
  logic [15:0] m0_w_data = 0;
  logic        m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [7:0]  m1_addr = 0;
  logic [15:0] m1_w_data = 0;

  logic        m0_gnt, m0_r_valid, m1_gnt, m1_r_valid, mem_rd, mem_wr;
  logic [15:0] m0_r_data, m1_r_data, mem_w_data;
  logic [7:0]  mem_addr;
  logic [15:0] mem_r_data = 0;

  logic        s_m0_gnt, s_m0_r_valid, s_m1_gnt, s_m1_r_valid, s_mem_rd, s_mem_wr;
  logic [15:0] s_m0_r_data, s_m1_r_data, s_mem_w_data;
  logic [7:0]  s_mem_addr;

  int total = 0;
  int bad   = 0;
  logic [16:0] exp_q[$];   // {port, data}
  logic [15:0] mem [256];

  always #5 clk = ~clk;

  dm_port_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_LOCK(8)) u_dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_w_data(m0_w_data),
    .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_r_valid(m0_r_valid), .m0_r_data(m0_r_data),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_w_data(m1_w_data),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_r_valid(m1_r_valid), .m1_r_data(m1_r_data),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_w_data(mem_w_data),
    .mem_r_data(mem_r_data));

  dm_port_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_LOCK(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_w_data(m0_w_data),
    .m0_lock(m0_lock), .m0_gnt(s_m0_gnt), .m0_r_valid(s_m0_r_valid), .m0_r_data(s_m0_r_data),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_w_data(m1_w_data),
    .m1_lock(m1_lock), .m1_gnt(s_m1_gnt), .m1_r_valid(s_m1_r_valid), .m1_r_data(s_m1_r_data),
    .mem_rd(s_mem_rd), .mem_wr(s_mem_wr), .mem_addr(s_mem_addr), .mem_w_data(s_mem_w_data),
    .mem_r_data(16'h0));

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return (a == 8'h09) ? 16'h1234 : {8'hA5, a};
  endfunction

  // Memory model for u_dut: synchronous read, one-cycle latency.
  always @(posedge clk) begin
    if (mem_rd) mem_r_data <= mem[mem_addr];
    if (mem_wr) mem[mem_addr] <= mem_w_data;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Monitor: read returns against scoreboard, command exclusivity.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rd_wr_excl", {s_mem_rd & s_mem_wr, mem_rd & mem_wr}, 0);
      if (m0_r_valid || m1_r_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rvalid", {m1_r_valid, m0_r_valid}, 0);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          chk("rvalid_port", {m1_r_valid, m0_r_valid}, e[16] ? 2'b10 : 2'b01);
          chk("rdata", e[16] ? m1_r_data : m0_r_data, e[15:0]);
          chk("rdata_other_zero", e[16] ? m0_r_data : m1_r_data, 0);
        end
      end
    end
  end

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic idle_all();
    m0_req = 0; m0_lock = 0; m0_we = 0;
    m1_req = 0; m1_lock = 0; m1_we = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_val(8'(i));

    // Power-on reset, then one m0 read beat of 0x05 followed by 3-cycle reset.
    next(); next();
    rst = 0;
    m0_req = 1; m0_we = 0; m0_addr = 8'h05;
    @(negedge clk);
    chk("pre_rst_gnt", {m0_gnt, mem_rd, mem_addr}, {1'b1, 1'b1, 8'h05});
    next();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_outputs", {m0_gnt, m0_r_valid, m0_r_data, m1_gnt, m1_r_valid, m1_r_data,
                          mem_rd, mem_wr, mem_addr, mem_w_data}, 0);
      chk("rst_outputs3", {s_m0_gnt, s_m0_r_valid, s_m0_r_data, s_m1_gnt, s_m1_r_valid,
                           s_m1_r_data, s_mem_rd, s_mem_wr, s_mem_addr, s_mem_w_data}, 0);
      next();
    end
    rst = 0; idle_all();
    @(negedge clk);
    chk("post_rst_no_rvalid", {m0_r_valid, m1_r_valid}, 0);
    next();

    // Single m1 read of 0x09.
    m1_req = 1; m1_we = 0; m1_addr = 8'h09;
    @(negedge clk);
    chk("single_rd_cmd", {m1_gnt, m0_gnt, mem_rd, mem_wr, mem_addr}, {4'b1010, 8'h09});
    exp_q.push_back({1'b1, init_val(8'h09)});
    next();
    idle_all();
    @(negedge clk);
    chk("single_rd_ret", {m1_r_valid, m0_r_valid}, 2'b10);
    chk("no_grant_cmd", {mem_rd, mem_wr, mem_addr, mem_w_data}, 0);
    next();

    // Collision: m0 write vs m1 read, port 0 wins, m1 next.
    m0_req = 1; m0_we = 1; m0_addr = 8'h01; m0_w_data = 16'h00AA;
    m1_req = 1; m1_we = 0; m1_addr = 8'h02;
    @(negedge clk);
    chk("coll_m0", {m0_gnt, m1_gnt, mem_wr, mem_rd, mem_addr, mem_w_data},
        {4'b1010, 8'h01, 16'h00AA});
    next();
    m0_req = 0;
    @(negedge clk);
    chk("coll_m1", {m0_gnt, m1_gnt, mem_rd, mem_addr}, {3'b011, 8'h02});
    exp_q.push_back({1'b1, init_val(8'h02)});
    next();
    idle_all();
    next();

    // Lock burst: 4 m0 write beats, m1 read waiting.
    m1_req = 1; m1_we = 0; m1_addr = 8'h03;
    m0_req = 1; m0_we = 1; m0_lock = 1;
    for (int i = 0; i < 4; i++) begin
      m0_addr = 8'h10 + 8'(i); m0_w_data = 16'h5010 + 16'(i);
      if (i == 3) m0_lock = 0;
      @(negedge clk);
      chk("burst_owner", {m0_gnt, m1_gnt, mem_wr, mem_addr}, {3'b101, 8'h10 + 8'(i)});
      next();
    end
    m0_req = 0; m0_lock = 0;
    @(negedge clk);
    chk("burst_release", {m0_gnt, m1_gnt, mem_rd, mem_addr}, {3'b011, 8'h03});
    exp_q.push_back({1'b1, init_val(8'h03)});
    next();
    idle_all();

    // Read back data written earlier.
    m0_req = 1; m0_we = 0; m0_addr = 8'h11;
    @(negedge clk);
    chk("rb_gnt", m0_gnt, 1);
    exp_q.push_back({1'b0, 16'h5011});
    next();
    m0_addr = 8'h01;    // back-to-back read
    @(negedge clk);
    chk("rb2_gnt", m0_gnt, 1);
    exp_q.push_back({1'b0, 16'h00AA});
    next();
    idle_all();
    next();

    // Starvation limit on u_dut3 (MAX_LOCK=3).
    rst = 1; next(); rst = 0;
    m0_req = 1; m0_we = 1; m0_lock = 1; m0_addr = 8'h20; m0_w_data = 16'h2020;
    m1_req = 1; m1_we = 1; m1_lock = 0; m1_addr = 8'h30; m1_w_data = 16'h3030;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("starve_m0_beat", {s_m0_gnt, s_m1_gnt}, 2'b10);
      next();
    end
    @(negedge clk);
    chk("starve_gap", {s_m0_gnt, s_m1_gnt, s_mem_wr, s_mem_rd}, 0);
    next();
    @(negedge clk);
    chk("starve_m1_win", {s_m0_gnt, s_m1_gnt, s_mem_addr}, {2'b01, 8'h30});
    next();
    idle_all();
    next();

    // Continuous single-beat requests from both ports.
    rst = 1; next(); rst = 0;
    m0_req = 1; m0_we = 1; m0_addr = 8'h40; m0_w_data = 16'h4040;
    m1_req = 1; m1_we = 1; m1_addr = 8'h41; m1_w_data = 16'h4141;
    for (int i = 0; i < 8; i++) begin
      logic e0;
      e0 = RR ? (i % 2 == 0) : 1'b1;
      @(negedge clk);
      chk("arb_seq", {m0_gnt, m1_gnt}, {e0, ~e0});
      chk("arb_seq3", {s_m0_gnt, s_m1_gnt}, {e0, ~e0});
      next();
    end
    idle_all();
    next(); next();

    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Two-requester arbiter that shares the single-port 256x16 data memory between the SPU core (port 0) and a host/loader port (port 1).
- Port 1 preloads operands and reads back results while the SPU runs.
- Sits between spu dm_* outputs and the DM macro.
- Provides per-beat arbitration, burst locking with a starvation limit, and registered read-return steering.

Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 16, memory data width
- MAX_LOCK, 8, maximum consecutive locked beats before forced release (range 1..255)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- m0_req  in  1  SPU access request
- m0_we  in  1  1=write, 0=read
- m0_addr  in  ADDR_W  SPU address
- m0_w_data  in  DATA_W  SPU write data
- m0_lock  in  1  SPU holds ownership after this beat
- m0_gnt  out  1  access accepted this cycle
- m0_r_valid  out  1  read data for m0 valid
- m0_r_data  out  DATA_W  read data
- m1_req, m1_we, m1_addr, m1_w_data, m1_lock, m1_gnt, m1_r_valid, m1_r_data: same meaning, host port
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_w_data  out  DATA_W  memory write data
- mem_r_data  in  DATA_W  memory read data, valid one cycle after mem_rd

Behaviour:
- Reset, synchronous and active-high: state=IDLE, lock_cnt=0, rr_ptr=0, rd_tag=none. While rst=1, all outputs are 0.
- One beat per cycle. mX_gnt is combinational from req/state and is never high for both ports.
- A beat transfers when mX_req and mX_gnt are both high in the same cycle.
- Memory command is combinational from the granted port:
  - mem_rd = gnt & ~we; mem_wr = gnt & we.
  - mem_addr and mem_w_data are muxed from the granted port.
  - With no grant: mem_rd=mem_wr=0 and mem_addr/mem_w_data=0.
  - mem_rd and mem_wr are never both 1.
- Read return:
  - rd_tag is registered at a read beat.
  - Next cycle, mX_r_valid=1 for the tagged port only, and mX_r_data=mem_r_data.
  - Otherwise mX_r_data=0.
  - Read latency is exactly 1 cycle, and back-to-back reads are allowed.
- FSM states: IDLE, OWN0, OWN1.
- IDLE:
  - Pick a winner by priority (fixed: port 0 wins).
  - Winner beat with lock=1: go to OWNwinner, lock_cnt=1.
  - Otherwise stay in IDLE.
- OWNx:
  - Only port x may be granted. The other port's gnt=0 even if it requests.
  - Beat with lock=1 and lock_cnt<MAX_LOCK: stay, lock_cnt+1.
  - Beat with lock=0: go to IDLE.
  - mX_req=0: go to IDLE; no beat that cycle; the other port is not granted that cycle.
  - lock_cnt==MAX_LOCK and the other port requesting: gnt=0 for x, go to IDLE, and the other port must win the next IDLE arbitration regardless of priority (starve flag, cleared on that grant).
  - lock_cnt==MAX_LOCK and no other request: lock_cnt stays saturated and x keeps the grant.
- lock_cnt:
  - 8-bit, saturating at MAX_LOCK.
  - Cleared on entry to IDLE.
- Simultaneous requests in IDLE with starve=0: priority decides. The loser's signals are ignored, with no buffering; the loser holds req.
- Changing addr/we/data while req=1 and gnt=0 is legal.
- Reset mid-operation: any outstanding read's r_valid is dropped, and ownership and starve are cleared.

Optional Feature:
- DM_ARB_RR_EN.
- Defined: IDLE arbitration is round-robin.
  - rr_ptr names the port preferred next.
  - On each IDLE grant, rr_ptr becomes the non-granted port.
  - The starve flag overrides rr_ptr.
- Undefined: fixed priority, port 0 always wins IDLE ties; rr_ptr logic absent.

Test Plan:
- Reset check: assert rst 3 cycles during m0 read of addr 0x05 -> all outputs 0, no m0_r_valid the cycle after release, FSM IDLE.
- Single read: mem[0x09]=0x1234; m1_req=1, we=0, addr 0x09 in IDLE with m0 idle -> m1_gnt=1, mem_rd=1, mem_addr=0x09; next cycle m1_r_valid=1, m1_r_data=0x1234, m0_r_valid=0.
- Collision, fixed priority: m0 write 0x00AA@0x01 and m1 read @0x02 in same cycle -> m0_gnt=1, mem_wr=1, m1_gnt=0; next cycle m1 granted, mem_rd=1 addr 0x02.
- Lock burst: m0 lock=1 for 4 write beats to 0x10..0x13 while m1_req=1 -> m1_gnt=0 during all 4 beats; m0 deasserts lock on 4th beat -> m1 granted next cycle.
- Starvation limit with MAX_LOCK=3: m0 requests with lock=1 continuously while m1 requests -> 3 m0 beats, 1 cycle with no grant, then m1 granted despite m0 request.
- DM_ARB_RR_EN defined: both ports request single beats continuously -> grants alternate m0, m1, m0, m1 for 8 cycles; undefined -> m0 granted all 8 cycles.
